// File: rtl/dpi_pkt_feeder.sv
// dpi_pkt_feeder: producer side of the per-regex matcher stream interface.
// Maps each packet's flow tag to a stream ID, then serialises its payload.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data/in_vld/     ingress words; header = {flow tag, byte length},
//   in_sop/in_eop/      payload byte0 in [31:24]; a word is consumed
//   in_rdy              when in_vld & in_rdy
//   enable_mask         per-stream matcher enable, indexed by stream_id
//   char_out(_vld)      payload bytes, one per cycle, MSB first
//   load_state          1-cycle start-of-packet pulse
//   stream_id           table index, held from load_state through eop
//   new_stream_id       with load_state: 1 = tag missed, entry allocated
//   eop, enable         1-cycle end-of-packet pulse, enable_mask[stream_id]
//   err                 sticky framing error
//   pkt_cnt, new_cnt    packet / table-miss counters
//
// Optional macro DPI_FEEDER_STATS_EN builds pkt_cnt/new_cnt counters;
// without it both outputs are tied to zero.

module dpi_pkt_feeder #(
    parameter int LOAD_GAP = 2,
    parameter int EOP_GAP  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_data,
    input  logic        in_vld,
    input  logic        in_sop,
    input  logic        in_eop,
    output logic        in_rdy,
    input  logic [63:0] enable_mask,
    output logic [7:0]  char_out,
    output logic        char_out_vld,
    output logic        load_state,
    output logic [5:0]  stream_id,
    output logic        new_stream_id,
    output logic        eop,
    output logic        enable,
    output logic        err,
    output logic [15:0] pkt_cnt,
    output logic [15:0] new_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_LOAD,
        S_GAP,
        S_DATA,
        S_DRAIN,
        S_EOP
    } state_t;

    state_t      state;
    logic [15:0] tag_q;
    logic [15:0] rem_q;
    logic [31:0] hold_q;
    logic [2:0]  hold_cnt;
    logic [2:0]  cnt_q;
    logic [5:0]  victim_q;

    logic [15:0] tag_tbl [64];
    logic [63:0] tag_vld;

    logic        hit;
    logic [5:0]  hit_idx;
    logic [2:0]  take;
    logic        pay_acc;
    logic        gap_last;
    logic        drain_last;
    logic        eop_short;
    logic        eop_missing;

    // Descending scan so the lowest matching index is the one kept.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 63; i >= 0; i--) begin
            if (tag_vld[i] && tag_tbl[i] == tag_q) begin
                hit     = 1'b1;
                hit_idx = 6'(i);
            end
        end
    end

    assign gap_last   = (cnt_q == 3'(LOAD_GAP - 1));
    assign drain_last = (cnt_q == 3'(EOP_GAP - 1));

    // Payload words are taken in DATA and also in the last GAP cycle, so
    // the first byte lands exactly LOAD_GAP idle cycles after load_state.
    assign pay_acc = in_vld && in_rdy &&
                     (state == S_GAP || state == S_DATA);

    assign take        = (rem_q >= 16'd4) ? 3'd4 : rem_q[2:0];
    assign eop_short   = in_eop && (rem_q > 16'd4);
    assign eop_missing = !in_eop && (rem_q <= 16'd4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            for (int i = 0; i < 64; i++) begin
                tag_tbl[i] <= '0;
            end
        end else if (state == S_LOOKUP && !hit) begin
            tag_vld[victim_q] <= 1'b1;
            tag_tbl[victim_q] <= tag_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            in_rdy        <= 1'b0;
            char_out      <= '0;
            char_out_vld  <= 1'b0;
            load_state    <= 1'b0;
            stream_id     <= '0;
            new_stream_id <= 1'b0;
            eop           <= 1'b0;
            enable        <= 1'b0;
            err           <= 1'b0;
            tag_q         <= '0;
            rem_q         <= '0;
            hold_q        <= '0;
            hold_cnt      <= '0;
            cnt_q         <= '0;
            victim_q      <= '0;
        end else begin
            char_out_vld  <= 1'b0;
            load_state    <= 1'b0;
            new_stream_id <= 1'b0;
            eop           <= 1'b0;
            enable        <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    in_rdy <= 1'b1;
                    if (in_vld && in_rdy) begin
                        if (in_sop) begin
                            tag_q  <= in_data[31:16];
                            rem_q  <= in_data[15:0];
                            in_rdy <= 1'b0;
                            state  <= S_LOOKUP;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_LOOKUP: begin
                    load_state    <= 1'b1;
                    new_stream_id <= !hit;
                    state         <= S_LOAD;
                    if (hit) begin
                        stream_id <= hit_idx;
                    end else begin
                        stream_id <= victim_q;
                        victim_q  <= victim_q + 6'd1;
                    end
                end
                S_LOAD: begin
                    cnt_q    <= '0;
                    hold_cnt <= '0;
                    state    <= S_GAP;
                end
                S_GAP: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'(LOAD_GAP - 2)) begin
                        in_rdy <= (rem_q != 16'd0);
                    end
                    if (gap_last) begin
                        cnt_q <= '0;
                        state <= (rem_q == 16'd0) ? S_DRAIN : S_DATA;
                    end
                end
                S_DATA: begin
                    if (rem_q == 16'd0) begin
                        in_rdy <= 1'b0;
                        cnt_q  <= '0;
                        state  <= S_DRAIN;
                    end else if (hold_cnt != 3'd0) begin
                        char_out     <= hold_q[31:24];
                        char_out_vld <= 1'b1;
                        hold_q       <= {hold_q[23:0], 8'h00};
                        hold_cnt     <= hold_cnt - 3'd1;
                        rem_q        <= rem_q - 16'd1;
                        in_rdy       <= (hold_cnt == 3'd1) &&
                                        (rem_q != 16'd1);
                    end
                end
                S_DRAIN: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (drain_last) begin
                        eop    <= 1'b1;
                        enable <= enable_mask[stream_id];
                        state  <= S_EOP;
                    end
                end
                S_EOP: begin
                    in_rdy <= 1'b1;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Byte 0 goes straight out; the rest wait in the holding
            // buffer. An early in_eop trims the count to this word.
            if (pay_acc) begin
                char_out     <= in_data[31:24];
                char_out_vld <= 1'b1;
                hold_q       <= {in_data[23:0], 8'h00};
                hold_cnt     <= take - 3'd1;
                rem_q        <= eop_short ? 16'd3 : rem_q - 16'd1;
                in_rdy       <= 1'b0;
                if (in_sop || eop_short || eop_missing) begin
                    err <= 1'b1;
                end
            end
        end
    end

`ifdef DPI_FEEDER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
            new_cnt <= '0;
        end else begin
            if (state == S_EOP) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
            if (state == S_LOOKUP && !hit) begin
                new_cnt <= new_cnt + 16'd1;
            end
        end
    end
`else
    assign pkt_cnt = '0;
    assign new_cnt = '0;
`endif

endmodule
